mul_issue_queue: RTL and testbench

//  Request buffer and sequencer that sits directly in front of the iterative Multiplier. It accepts operand

---
 rtl/mul_issue_queue_pkg.sv | 22 ++
 rtl/mul_issue_queue_op_fifo.sv | 63 ++++++
 rtl/mul_issue_queue.sv | 181 ++++++++++++++++++
 tb/tb_mul_issue_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_queue_pkg.sv
// Shared types and default parameters for the multiplier issue queue.
// The sequencer state enum and the watchdog counter width helper live here.
package mul_issue_queue_pkg;

  localparam int LEN_DEF     = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int TAG_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } mq_state_e;

  // Watchdog counts 0..timeout-1, so clog2(timeout) bits always suffice.
  function automatic int wd_cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mul_issue_queue_op_fifo.sv
// Synchronous request FIFO holding {tag, b, a} entries for the issue queue.
// Full/empty come from the registered count; a push while full is dropped.
module mul_issue_queue_op_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mul_issue_queue.sv
// Buffers operand pairs, issues them one at a time to an iterative multiplier
// via start/finish, and returns tagged products; a watchdog aborts hung multiplies.
module mul_issue_queue
  import mul_issue_queue_pkg::*;
#(
  parameter int LEN     = LEN_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEN-1:0]     req_a,
  input  logic [LEN-1:0]     req_b,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               mul_start,
  output logic [LEN-1:0]     mul_multiplicand,
  output logic [LEN-1:0]     mul_multiplier,
  input  logic [2*LEN-1:0]   mul_product,
  input  logic               mul_finish,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*LEN-1:0]   res_product,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic               busy,
  output logic               timeout_err
);

  localparam int FW    = 2*LEN + TAG_W;
  localparam int CNT_W = wd_cnt_width(TIMEOUT);

  mq_state_e             r_state;
  mq_state_e             w_next_state;
  logic [FW-1:0]         w_fifo_wdata;
  logic [FW-1:0]         w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                  w_pop;
  logic                  w_wd_expire;
  logic                  w_mul_start;
  logic                  w_res_valid;
  logic                  w_busy;
  logic [LEN-1:0]        r_a;
  logic [LEN-1:0]        r_b;
  logic [TAG_W-1:0]      r_tag;
  logic [2*LEN-1:0]      r_product;
  logic                  r_err;
  logic                  r_timeout_err;
  logic [CNT_W-1:0]      r_wd_cnt;

  assign w_fifo_wdata = {req_tag, req_b, req_a};
  assign w_pop        = (r_state == ST_IDLE) & ~w_fifo_empty;
  assign w_wd_expire  = (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  mul_issue_queue_op_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (req_valid),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; finish takes priority over watchdog expiry
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (mul_finish || w_wd_expire) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    w_mul_start = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = (r_state != ST_IDLE) || (w_fifo_count != '0);
    case (r_state)
      ST_ISSUE: w_mul_start = 1'b1;
      ST_HOLD:  w_res_valid = 1'b1;
      default: begin
        w_mul_start = 1'b0;
        w_res_valid = 1'b0;
      end
    endcase
  end

  // Operands and tag are loaded on pop and stay put until the next pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a   <= {LEN{1'b0}};
      r_b   <= {LEN{1'b0}};
      r_tag <= {TAG_W{1'b0}};
    end else if (w_pop) begin
      r_a   <= w_fifo_rdata[LEN-1:0];
      r_b   <= w_fifo_rdata[2*LEN-1:LEN];
      r_tag <= w_fifo_rdata[FW-1:2*LEN];
    end
  end

  // Watchdog: cleared while issuing, counts each WAIT cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wd_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_ISSUE) begin
      r_wd_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_WAIT) && !w_wd_expire) begin
      r_wd_cnt <= r_wd_cnt + CNT_W'(1);
    end
  end

  // Result capture; mul_product is only trusted in a WAIT-state finish cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_product     <= {(2*LEN){1'b0}};
      r_err         <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (mul_finish) begin
        r_product <= mul_product;
        r_err     <= 1'b0;
      end else if (w_wd_expire) begin
        r_product     <= {(2*LEN){1'b0}};
        r_err         <= 1'b1;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign req_ready        = ~w_fifo_full;
  assign mul_start        = w_mul_start;
  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;
  assign res_valid        = w_res_valid;
  assign res_product      = r_product;
  assign res_tag          = r_tag;
  assign res_err          = r_err;
  assign busy             = w_busy;
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Scoreboard bench for mul_issue_queue with a behavioural multiplier stub.
module tb_mul_issue_queue;

  localparam int LEN = 32, DEPTH = 4, TAG_W = 4, TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rstn, req_valid, req_ready, mul_start, mul_finish;
  logic [LEN-1:0]   req_a, req_b, mul_multiplicand, mul_multiplier;
  logic [TAG_W-1:0] req_tag, res_tag;
  logic [2*LEN-1:0] mul_product, res_product;
  logic             res_valid, res_ready, res_err, busy, timeout_err;

  always #5 clk = ~clk;

  mul_issue_queue #(.LEN(LEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_finish(mul_finish), .res_valid(res_valid),
    .res_ready(res_ready), .res_product(res_product), .res_tag(res_tag),
    .res_err(res_err), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   stub_mode = 0, fixed_lat = 0, ready_mode = 1;
  bit   glitch_en = 0, pend = 0, fin_real_prev = 0;
  int   cnt = 0, start_cycle = -1, wait_entry = -1, n_starts = 0, n_results = 0;
  logic [31:0] sa, sb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at a later negedge after the request was accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      output int acc_edge);
    int n = 0;
    exp_t e;
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      acc_edge = -1;
    end else begin
      acc_edge = cyc + 1;
      e.prod = (stub_mode == 1) ? 64'd0 : 64'(a) * 64'(b);
      e.tag = tag;
      e.err = (stub_mode == 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer ready, changed just after the active edge
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  // Multiplier stub: finishes cnt WAIT cycles after start; may glitch finish when idle
  initial begin
    logic [63:0] p;
    mul_finish = 1'b0; mul_product = '0;
    forever begin
      @(negedge clk);
      if (fin_real_prev) chk("res_valid_after_finish", 64'(res_valid), 64'd1);
      fin_real_prev = 0;
      mul_finish = 1'b0;
      mul_product = {$urandom, $urandom};
      if (!rstn) begin
        pend = 0;
      end else if (mul_start) begin
        sa = mul_multiplicand; sb = mul_multiplier;
        start_cycle = cyc + 1; wait_entry = cyc + 1; n_starts++;
        pend = (stub_mode == 0);
        cnt = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 40);
        if (glitch_en) mul_finish = ($urandom_range(0, 2) == 0);
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          chk("operands_held", {mul_multiplicand, mul_multiplier}, {sa, sb});
          p = 64'(sa) * 64'(sb);
          mul_finish = 1'b1; mul_product = p;
          pend = 0; fin_real_prev = 1;
        end
      end else if (glitch_en) begin
        mul_finish = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor: every accepted result is checked against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && res_valid && res_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_product", res_product, e.prod);
          chk("res_tag", 64'(res_tag), 64'(e.tag));
          chk("res_err", 64'(res_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc, n, nst, nres;
    logic [63:0] hp;
    logic [3:0]  ht;
    rstn = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_outputs", {res_valid, mul_start, busy, timeout_err, res_err}, 64'd0);
    chk("rst_payload", res_product | 64'(res_tag), 64'd0);

    // Single request latency
    send(32'd3, 32'd5, 4'd1, acc);
    n = 0;
    while (start_cycle == -1 && n < 20) begin @(negedge clk); n++; end
    chk("start_latency", 64'(start_cycle), 64'(acc + 2));
    drain("drain_single");

    // Back-to-back extremes
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, acc);
    send(32'd0, 32'h1234, 4'd3, acc);
    drain("drain_b2b");

    // Fill: 1 in flight + DEPTH queued while the result is stalled
    ready_mode = 0; fixed_lat = 3; nres = n_results;
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 4'(i + 4), acc);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("full_still_blocked", {req_ready, busy}, 64'b01);
    ready_mode = 1;
    drain("drain_fill");
    chk("fill_result_count", 64'(n_results - nres), 64'd5);

    // HOLD stability with a queued follower
    ready_mode = 0;
    send(32'hDEAD_BEEF, 32'h10, 4'd9, acc);
    send(32'd7, 32'd6, 4'd10, acc);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    hp = res_product; ht = res_tag; nst = n_starts;
    chk("hold_first_product", hp, 64'hDEAD_BEEF * 64'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", {res_valid, res_tag, res_product[58:0]}, {1'b1, ht, hp[58:0]});
    end
    chk("hold_no_start", 64'(n_starts), 64'(nst));
    ready_mode = 1;
    drain("drain_hold");

    // Finish in the same cycle the watchdog would expire
    fixed_lat = TIMEOUT;
    send(32'h8000_0001, 32'h3, 4'd11, acc);
    drain("drain_finish_vs_timeout");
    fixed_lat = 0;

    // Hung multiplier: watchdog abort
    stub_mode = 1; wait_entry = -1;
    send(32'd100, 32'd200, 4'd12, acc);
    n = 0;
    while (!res_valid && n < 400) begin @(negedge clk); n++; end
    chk("timeout_latency", 64'(cyc), 64'(wait_entry + TIMEOUT));
    drain("drain_timeout");
    stub_mode = 0;
    send(32'd9, 32'd9, 4'd13, acc);
    drain("drain_after_timeout");
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-WAIT with two queued
    fixed_lat = 200; nres = n_results;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 4'(i), acc);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {busy, 1'(pend)}, 64'b11);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {res_valid, mul_start, busy, timeout_err, res_err, req_ready}, 64'b000001);
    chk("mid_rst_payload", res_product | 64'(res_tag) | 64'(mul_multiplicand) | 64'(mul_multiplier), 64'd0);
    exp_q.delete();
    rstn = 1'b1; fixed_lat = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", {busy, res_valid}, 64'd0);
    chk("post_rst_no_result", 64'(n_results - nres), 64'd0);

    // Random traffic with finish glitches and random back-pressure
    glitch_en = 1; ready_mode = 2;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 5))
        0:       send(32'hFFFF_FFFF, $urandom, 4'(i), acc);
        1:       send($urandom_range(0, 3), $urandom, 4'(i), acc);
        default: send($urandom, $urandom, 4'(i), acc);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("drain_random");
    glitch_en = 0; ready_mode = 1;
    repeat (5) @(negedge clk);
    chk("final_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
